updown_counter_param: RTL and testbench

Parametrised up/down counter, successor to the fixed 32-bit up/down counter. Adds:
- configurable width and count range;
- step size, count enable, synchronous clear, parallel load;
- wrap or saturate boundary mode, with overflow/underflow indication.

Used as a general event/position counter in datapath and control blocks. Single clock domain.

---
 rtl/updown_counter_param.sv | 185 ++++++++++++++++++
 tb/tb_updown_counter_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// ---------------------------------------------------------------------------
// updown_counter_param
//
// Parametrised up/down counter with step size, count enable, synchronous
// clear, parallel load (clamped into the legal range) and a choice of wrap
// or saturate behaviour at the range bounds. Crossing a bound produces a
// one-cycle ovf/udf pulse and sets a sticky err flag.
//
// Parameters:
//   WIDTH    counter width in bits (2..32)
//   MIN_VAL  lowest legal count value
//   MAX_VAL  highest legal count value (MIN_VAL < MAX_VAL <= 2^WIDTH-1)
//   STEP     count increment/decrement (1..MAX_VAL-MIN_VAL)
//   SAT_MODE 0 = wrap within [MIN_VAL,MAX_VAL], 1 = saturate at the bounds
//   RST_VAL  value loaded on reset/clear (MIN_VAL..MAX_VAL)
//
// Ports:
//   c       in   clock, rising edge active
//   r       in   asynchronous active-high reset
//   en      in   count enable
//   m       in   direction, 1 = up, 0 = down
//   clr     in   synchronous clear to RST_VAL, also clears err
//   ld      in   synchronous parallel load of d (clamped)
//   d       in   load data
//   q       out  current count (registered)
//   at_max  out  q == MAX_VAL
//   at_min  out  q == MIN_VAL
//   ovf     out  one-cycle pulse, up-count crossed MAX_VAL
//   udf     out  one-cycle pulse, down-count crossed MIN_VAL
//   err     out  sticky overflow/underflow flag
// ---------------------------------------------------------------------------
module updown_counter_param #(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MIN_VAL  = 0,
    parameter longint unsigned MAX_VAL  = 255,
    parameter longint unsigned STEP     = 1,
    parameter int              SAT_MODE = 0,
    parameter longint unsigned RST_VAL  = 0
) (
    input  logic             c,
    input  logic             r,
    input  logic             en,
    input  logic             m,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             udf,
    output logic             err
);

    localparam longint unsigned MAX_REPR = (64'd1 << WIDTH) - 64'd1;

    // Parameter legality: any illegal combination stops elaboration.
    if (WIDTH < 2 || WIDTH > 32) begin : g_badWidth
        $error("updown_counter_param: WIDTH must be in 2..32");
    end
    if (MIN_VAL >= MAX_VAL || MAX_VAL > MAX_REPR) begin : g_badRange
        $error("updown_counter_param: need MIN_VAL < MAX_VAL <= 2^WIDTH-1");
    end
    if (STEP < 1 || STEP > MAX_VAL - MIN_VAL) begin : g_badStep
        $error("updown_counter_param: STEP must be in 1..MAX_VAL-MIN_VAL");
    end
    if (SAT_MODE != 0 && SAT_MODE != 1) begin : g_badMode
        $error("updown_counter_param: SAT_MODE must be 0 or 1");
    end
    if (RST_VAL < MIN_VAL || RST_VAL > MAX_VAL) begin : g_badReset
        $error("updown_counter_param: RST_VAL must be in MIN_VAL..MAX_VAL");
    end

    localparam logic [WIDTH-1:0] MIN_Q   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] STEP_Q  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);
    // Range size modulo 2^WIDTH; a full-width range becomes 0, which is
    // still correct because wrap arithmetic below is done modulo 2^WIDTH.
    localparam logic [WIDTH-1:0] RANGE_Q = WIDTH'(MAX_VAL - MIN_VAL + 64'd1);
    localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   DNLIM_X = (WIDTH+1)'(MIN_VAL + STEP);

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic             r_udf;
    logic             r_err;

    logic [WIDTH:0]   w_sum;
    logic             w_upCross;
    logic             w_dnCross;
    logic [WIDTH-1:0] w_upWrap;
    logic [WIDTH-1:0] w_dnNoWrap;
    logic [WIDTH-1:0] w_dnWrap;
    logic [WIDTH-1:0] w_upNext;
    logic [WIDTH-1:0] w_dnNext;
    logic [WIDTH-1:0] w_ldLow;
    logic [WIDTH-1:0] w_ldClamp;

    // Up path: the sum carries one extra bit so a result past 2^WIDTH-1 is
    // still seen as a crossing. Down path: q < MIN_VAL+STEP is exactly the
    // condition q-STEP < MIN_VAL, without needing signed arithmetic.
    // Wrapped values always land inside the legal range, so computing them
    // modulo 2^WIDTH gives the exact answer.
    assign w_sum      = {1'b0, r_q} + {1'b0, STEP_Q};
    assign w_upCross  = (w_sum > MAX_X);
    assign w_dnCross  = ({1'b0, r_q} < DNLIM_X);
    assign w_upWrap   = r_q + STEP_Q - RANGE_Q;
    assign w_dnNoWrap = r_q - STEP_Q;
    assign w_dnWrap   = r_q - STEP_Q + RANGE_Q;

    // Choose the next count value for each direction, applying the
    // boundary mode when a crossing occurs.
    always_comb begin
        w_upNext = w_sum[WIDTH-1:0];
        w_dnNext = w_dnNoWrap;
        if (w_upCross) begin
            w_upNext = (SAT_MODE != 0) ? MAX_Q : w_upWrap;
        end
        if (w_dnCross) begin
            w_dnNext = (SAT_MODE != 0) ? MIN_Q : w_dnWrap;
        end
    end

    // Load clamping. A bound that coincides with the representable limit
    // can never be exceeded, so its comparison is left out entirely.
    if (MIN_VAL == 0) begin : g_noLowClamp
        assign w_ldLow = d;
    end else begin : g_lowClamp
        assign w_ldLow = (d < MIN_Q) ? MIN_Q : d;
    end
    if (MAX_VAL == MAX_REPR) begin : g_noHighClamp
        assign w_ldClamp = w_ldLow;
    end else begin : g_highClamp
        assign w_ldClamp = (w_ldLow > MAX_Q) ? MAX_Q : w_ldLow;
    end

    // Count register with priority reset > clear > load > enable. The
    // ovf/udf pulses are rewritten every edge so they last one cycle
    // unless the crossing repeats; err only ever sets here.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            r_q   <= RST_Q;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
            r_err <= 1'b0;
        end else if (clr) begin
            r_q   <= RST_Q;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
            r_err <= 1'b0;
        end else if (ld) begin
            r_q   <= w_ldClamp;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (en) begin
            if (m) begin
                r_q   <= w_upNext;
                r_ovf <= w_upCross;
                r_udf <= 1'b0;
                if (w_upCross) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_q   <= w_dnNext;
                r_ovf <= 1'b0;
                r_udf <= w_dnCross;
                if (w_dnCross) begin
                    r_err <= 1'b1;
                end
            end
        end else begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end
    end

    assign q      = r_q;
    assign at_max = (r_q == MAX_Q);
    assign at_min = (r_q == MIN_Q);
    assign ovf    = r_ovf;
    assign udf    = r_udf;
    assign err    = r_err;

endmodule

// File: tb/tb_updown_counter_param.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_param
//
// Directed bench for updown_counter_param. Three instances share one set of
// inputs: a default 0..255 step-1 wrap counter, a 0..9 step-3 wrap counter
// and a 2..9 step-3 saturating counter that resets to 5. Each step drives
// the inputs, waits one rising edge and checks against hand-computed values.
// ---------------------------------------------------------------------------
module tb_updown_counter_param;

    logic       c;
    logic       r;
    logic       en;
    logic       m;
    logic       clr;
    logic       ld;
    logic [7:0] d;

    logic [7:0] qDef;
    logic       atMaxDef, atMinDef, ovfDef, udfDef, errDef;
    logic [7:0] qWrap;
    logic       atMaxWrap, atMinWrap, ovfWrap, udfWrap, errWrap;
    logic [7:0] qSat;
    logic       atMaxSat, atMinSat, ovfSat, udfSat, errSat;

    int compareCount;
    int mismatchCount;

    updown_counter_param uDef (
        .c(c), .r(r), .en(en), .m(m), .clr(clr), .ld(ld), .d(d),
        .q(qDef), .at_max(atMaxDef), .at_min(atMinDef),
        .ovf(ovfDef), .udf(udfDef), .err(errDef)
    );

    updown_counter_param #(
        .WIDTH(8), .MIN_VAL(0), .MAX_VAL(9), .STEP(3), .SAT_MODE(0), .RST_VAL(0)
    ) uWrap (
        .c(c), .r(r), .en(en), .m(m), .clr(clr), .ld(ld), .d(d),
        .q(qWrap), .at_max(atMaxWrap), .at_min(atMinWrap),
        .ovf(ovfWrap), .udf(udfWrap), .err(errWrap)
    );

    updown_counter_param #(
        .WIDTH(8), .MIN_VAL(2), .MAX_VAL(9), .STEP(3), .SAT_MODE(1), .RST_VAL(5)
    ) uSat (
        .c(c), .r(r), .en(en), .m(m), .clr(clr), .ld(ld), .d(d),
        .q(qSat), .at_max(atMaxSat), .at_min(atMinSat),
        .ovf(ovfSat), .udf(udfSat), .err(errSat)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one set of inputs and advance past the next rising edge.
    task automatic applyStimulus(input logic iEn, input logic iM,
                                 input logic iClr, input logic iLd,
                                 input logic [7:0] iD);
        en  = iEn;
        m   = iM;
        clr = iClr;
        ld  = iLd;
        d   = iD;
        @(posedge c);
        #1;
    endtask

    // Directed sequence, one phase after another.
    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        r   = 1'b1;
        en  = 1'b0;
        m   = 1'b0;
        clr = 1'b0;
        ld  = 1'b0;
        d   = 8'd0;

        // Reset held across two edges
        repeat (2) @(posedge c);
        #1;
        checkOutput("rst_def_q", 32'(qDef), 0);
        checkOutput("rst_def_atmin", 32'(atMinDef), 1);
        checkOutput("rst_sat_q", 32'(qSat), 5);
        checkOutput("rst_wrap_ovf", 32'(ovfWrap), 0);
        checkOutput("rst_sat_err", 32'(errSat), 0);
        r = 1'b0;

        // Count up four edges
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("up1_def_q", 32'(qDef), 1);
        checkOutput("up1_wrap_q", 32'(qWrap), 3);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("up2_def_q", 32'(qDef), 2);
        checkOutput("up2_wrap_q", 32'(qWrap), 6);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("up3_def_q", 32'(qDef), 3);
        checkOutput("up3_wrap_q", 32'(qWrap), 9);
        checkOutput("up3_wrap_ovf", 32'(ovfWrap), 0);
        checkOutput("up3_wrap_atmax", 32'(atMaxWrap), 1);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("up4_def_q", 32'(qDef), 4);
        checkOutput("up4_wrap_q", 32'(qWrap), 2);
        checkOutput("up4_wrap_ovf", 32'(ovfWrap), 1);
        checkOutput("up4_wrap_err", 32'(errWrap), 1);

        // Count down four edges, direction change is immediate
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("dn1_def_q", 32'(qDef), 3);
        checkOutput("dn1_wrap_q", 32'(qWrap), 9);
        checkOutput("dn1_wrap_udf", 32'(udfWrap), 1);
        checkOutput("dn1_wrap_ovf", 32'(ovfWrap), 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("dn2_def_q", 32'(qDef), 2);
        checkOutput("dn2_wrap_udf", 32'(udfWrap), 0);
        checkOutput("dn2_wrap_err", 32'(errWrap), 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("dn3_def_q", 32'(qDef), 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("dn4_def_q", 32'(qDef), 0);
        checkOutput("dn4_def_atmin", 32'(atMinDef), 1);

        // Synchronous clear back to the reset values
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("clr_wrap_q", 32'(qWrap), 0);
        checkOutput("clr_wrap_err", 32'(errWrap), 0);
        checkOutput("clr_sat_q", 32'(qSat), 5);

        // Saturating down count from 5 with step 3
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("sdn1_sat_q", 32'(qSat), 2);
        checkOutput("sdn1_sat_udf", 32'(udfSat), 0);
        checkOutput("sdn1_def_q", 32'(qDef), 255);
        checkOutput("sdn1_def_udf", 32'(udfDef), 1);
        checkOutput("sdn1_wrap_q", 32'(qWrap), 7);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("sdn2_sat_q", 32'(qSat), 2);
        checkOutput("sdn2_sat_udf", 32'(udfSat), 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("sdn3_sat_q", 32'(qSat), 2);
        checkOutput("sdn3_sat_udf", 32'(udfSat), 1);
        checkOutput("sdn3_sat_atmin", 32'(atMinSat), 1);
        checkOutput("sdn3_sat_err", 32'(errSat), 1);

        // Saturating up count into MAX_VAL, then pause
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("sup1_sat_q", 32'(qSat), 5);
        checkOutput("sup1_sat_udf", 32'(udfSat), 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("sup2_sat_q", 32'(qSat), 8);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("sup3_sat_q", 32'(qSat), 9);
        checkOutput("sup3_sat_ovf", 32'(ovfSat), 1);
        checkOutput("sup3_wrap_q", 32'(qWrap), 0);
        checkOutput("sup3_wrap_ovf", 32'(ovfWrap), 1);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("sup4_sat_q", 32'(qSat), 9);
        checkOutput("sup4_sat_ovf", 32'(ovfSat), 1);
        checkOutput("sup4_sat_atmax", 32'(atMaxSat), 1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("hold_sat_q", 32'(qSat), 9);
        checkOutput("hold_sat_ovf", 32'(ovfSat), 0);
        checkOutput("hold_wrap_q", 32'(qWrap), 3);

        // Parallel load with clamping
        applyStimulus(0, 0, 0, 1, 8'd7);
        checkOutput("ld7_wrap_q", 32'(qWrap), 7);
        checkOutput("ld7_def_q", 32'(qDef), 7);
        applyStimulus(0, 0, 0, 1, 8'd200);
        checkOutput("ld200_wrap_q", 32'(qWrap), 9);
        checkOutput("ld200_wrap_atmax", 32'(atMaxWrap), 1);
        checkOutput("ld200_def_q", 32'(qDef), 200);
        applyStimulus(0, 0, 0, 1, 8'd1);
        checkOutput("ld1_sat_q", 32'(qSat), 2);
        checkOutput("ld1_sat_atmin", 32'(atMinSat), 1);
        checkOutput("ld1_wrap_q", 32'(qWrap), 1);
        applyStimulus(1, 1, 0, 1, 8'd4);
        checkOutput("ldEn_wrap_q", 32'(qWrap), 4);
        checkOutput("ldEn_sat_q", 32'(qSat), 4);
        checkOutput("ldEn_wrap_ovf", 32'(ovfWrap), 0);
        applyStimulus(0, 0, 0, 1, 8'd6);
        checkOutput("ld6_wrap_q", 32'(qWrap), 6);
        checkOutput("ld6_wrap_err", 32'(errWrap), 1);

        // Clear wins over load and enable
        applyStimulus(1, 1, 1, 1, 8'd3);
        checkOutput("prio_wrap_q", 32'(qWrap), 0);
        checkOutput("prio_wrap_err", 32'(errWrap), 0);
        checkOutput("prio_wrap_ovf", 32'(ovfWrap), 0);
        checkOutput("prio_wrap_udf", 32'(udfWrap), 0);
        checkOutput("prio_sat_q", 32'(qSat), 5);

        // Count to 4, then assert reset between edges
        repeat (4) applyStimulus(1, 1, 0, 0, 0);
        checkOutput("pre_def_q", 32'(qDef), 4);
        checkOutput("pre_sat_ovf", 32'(ovfSat), 1);
        #3;
        r = 1'b1;
        #1;
        checkOutput("async_def_q", 32'(qDef), 0);
        checkOutput("async_sat_q", 32'(qSat), 5);
        checkOutput("async_sat_ovf", 32'(ovfSat), 0);
        checkOutput("async_sat_err", 32'(errSat), 0);
        @(posedge c);
        #1;
        checkOutput("inrst_def_q", 32'(qDef), 0);
        r = 1'b0;
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("resume_def_q", 32'(qDef), 1);
        checkOutput("resume_wrap_q", 32'(qWrap), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compareCount, mismatchCount);
        $finish;
    end

endmodule
